// File: rtl/mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_div_unit                                                            |
// | Multicycle signed MULT/DIV (shift-add / restoring) producing HI and LO.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MULT = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opnd;
   logic               r_sa, r_sb, r_op, r_dz;
   logic [WIDTH-1:0]   r_hi, r_lo;

   logic [WIDTH-1:0]   w_ma, w_mb;
   logic [WIDTH:0]     w_msum, w_rsh, w_trial;
   logic [2*WIDTH-1:0] w_mult_nxt, w_div_nxt, w_prod;
   logic [WIDTH-1:0]   w_quot, w_rem;
   logic               w_last;

   assign w_ma   = A[WIDTH-1] ? -A : A;
   assign w_mb   = B[WIDTH-1] ? -B : B;
   assign w_last = (r_cnt == CNT_W'(WIDTH-1));

   // Multiply: low half of r_acc holds the multiplier, consumed LSB first.
   assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
   assign w_mult_nxt = r_acc[0] ? {w_msum, r_acc[WIDTH-1:1]}
                                : {1'b0, r_acc[2*WIDTH-1:1]};

   // Divide: r_acc = {rem, quot}; the shifted remainder needs one extra bit.
   assign w_rsh     = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_trial   = w_rsh - {1'b0, r_opnd};
   assign w_div_nxt = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

   assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
   assign w_quot = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // A divide by zero spends one busy cycle in DIV and then skips to DONE.
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      div_zero    = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_state_nxt = op ? S_DIV : S_MULT;
         S_MULT: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = S_FIX;
         end
         S_DIV: begin
            busy = 1'b1;
            if (r_dz)        w_state_nxt = S_DONE;
            else if (w_last) w_state_nxt = S_FIX;
         end
         S_FIX: begin
            busy        = 1'b1;
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            div_zero    = r_dz;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= '0;
         r_acc  <= '0;
         r_opnd <= '0;
         r_sa   <= 1'b0;
         r_sb   <= 1'b0;
         r_op   <= 1'b0;
         r_dz   <= 1'b0;
         r_hi   <= '0;
         r_lo   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op  <= op;
                  r_sa  <= A[WIDTH-1];
                  r_sb  <= B[WIDTH-1];
                  r_dz  <= op && (B == '0);
                  r_cnt <= '0;
                  if (op) begin
                     r_acc  <= {{WIDTH{1'b0}}, w_ma};
                     r_opnd <= w_mb;
                  end else begin
                     r_acc  <= {{WIDTH{1'b0}}, w_mb};
                     r_opnd <= w_ma;
                  end
               end
            end
            S_MULT: begin
               r_acc <= w_mult_nxt;
               r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            S_DIV: begin
               if (!r_dz) begin
                  r_acc <= w_div_nxt;
                  r_cnt <= w_last ? '0 : r_cnt + 1'b1;
               end
            end
            S_FIX: begin
               if (r_op) begin
                  r_hi <= w_rem;
                  r_lo <= w_quot;
               end else begin
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign hi = r_hi;
   assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mult_div_unit                                                         |
// | Directed self-checking bench for mult_div_unit.                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mult_div_unit;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        op;
   logic [31:0] A, B;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(A), .B(B),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Launch at edge 0, then sample #1 after each edge until done (bounded).
   task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op = o; A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; A = $urandom; B = $urandom; op = 1'($urandom);
   endtask

   task automatic finish_op(input string tag, input int exp_lat, input logic exp_dz,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input int k0);
      int k = k0;
      int bcnt = k0;
      while (!done && k < 40) begin
         if (busy) bcnt++;
         @(posedge clk); #1;
         k++;
      end
      chk({tag, " latency"}, 32'(k), 32'(exp_lat));
      chk({tag, " busy cycles"}, 32'(bcnt), 32'(exp_lat));
      chk({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
      chk({tag, " hi"}, hi, exp_hi);
      chk({tag, " lo"}, lo, exp_lo);
      @(posedge clk); #1;
      chk({tag, " done pulse width"}, {30'd0, done, busy}, 32'd0);
   endtask

   task automatic run_op(input string tag, input logic o, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic exp_dz,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      launch(o, a, b);
      finish_op(tag, exp_lat, exp_dz, exp_hi, exp_lo, 0);
   endtask

   initial begin
      int dcnt;
      reset_n = 1'b0; start = 1'b0; op = 1'b0; A = '0; B = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy/done/dz", {29'd0, busy, done, div_zero}, 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      @(negedge clk); reset_n = 1'b1;

      run_op("mult 7*-3",    1'b0, 32'd7,        32'hFFFF_FFFD, 33, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("mult min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 33, 1'b0, 32'h4000_0000, 32'h0);
      run_op("mult ffff^2",  1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 33, 1'b0, 32'h0,         32'hFFFE_0001);
      run_op("div -7/2",     1'b1, 32'hFFFF_FFF9, 32'd2,         33, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div 7/-2",     1'b1, 32'd7,        32'hFFFF_FFFE, 33, 1'b0, 32'h1,         32'hFFFF_FFFD);
      run_op("div min/-1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b0, 32'h0,         32'h8000_0000);
      run_op("div 3412/100", 1'b1, 32'h0000_3412, 32'h0000_0100, 33, 1'b0, 32'h12,        32'h34);
      run_op("div 5/0",      1'b1, 32'd5,        32'd0,         1,  1'b1, 32'h12,        32'h34);

      // A start pulse during MULT must be ignored.
      launch(1'b0, 32'd5, 32'd6);
      repeat (9) @(posedge clk);
      @(negedge clk); start = 1'b1; op = 1'b1; A = 32'd9; B = 32'd0;
      @(posedge clk); #1; start = 1'b0;
      finish_op("mult ignore start", 33, 1'b0, 32'h0, 32'd30, 10);
      dcnt = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (done || busy) dcnt++;
      end
      chk("no second op", 32'(dcnt), 32'd0);

      // Asynchronous reset in the middle of a DIV.
      launch(1'b1, 32'd100, 32'd7);
      repeat (15) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async reset busy/done", {30'd0, busy, done}, 32'd0);
      chk("async reset hi", hi, 32'd0);
      chk("async reset lo", lo, 32'd0);
      @(negedge clk); reset_n = 1'b1;
      run_op("mult 3*4 after reset", 1'b0, 32'd3, 32'd4, 33, 1'b0, 32'h0, 32'd12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
